// File: rtl/relay_link_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : relay_defs (package)
// Brief   : Mode codes, frame patterns, FSM/role encodings for the relay link.
// Revision: 1.0 - initial release
// ============================================================================
package relay_defs;

    localparam logic [2:0] MODE_SNIFFER       = 3'd0;
    localparam logic [2:0] MODE_TAGSIM_LISTEN = 3'd1;
    localparam logic [2:0] MODE_TAGSIM_MOD    = 3'd2;
    localparam logic [2:0] MODE_READER_LISTEN = 3'd3;
    localparam logic [2:0] MODE_READER_MOD    = 3'd4;
    localparam logic [2:0] MODE_FAKE_READER   = 3'd5;
    localparam logic [2:0] MODE_FAKE_TAG      = 3'd6;

    localparam logic [7:0]  START_READER_DEF   = 8'h0c;
    localparam logic [7:0]  START_TAG_DEF      = 8'hf0;
    localparam logic [15:0] END_ALT_READER_DEF = 16'hc000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_GUARD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ROLE_NONE   = 2'd0,
        ROLE_READER = 2'd1,
        ROLE_TAG    = 2'd2
    } role_t;

    function automatic role_t decode_role(input logic [2:0] mode);
        case (mode)
            MODE_FAKE_READER: return ROLE_READER;
            MODE_FAKE_TAG:    return ROLE_TAG;
            default:          return ROLE_NONE;
        endcase
    endfunction

    function automatic logic [2:0] listen_code(input role_t role);
        case (role)
            ROLE_READER: return MODE_READER_LISTEN;
            ROLE_TAG:    return MODE_TAGSIM_LISTEN;
            default:     return MODE_SNIFFER;
        endcase
    endfunction

    function automatic logic [2:0] mod_code(input role_t role);
        case (role)
            ROLE_READER: return MODE_READER_MOD;
            ROLE_TAG:    return MODE_TAGSIM_MOD;
            default:     return MODE_SNIFFER;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/relay_link_ctrl_frame_detect.sv
`default_nettype none
// ============================================================================
// Module  : relay_frame_detect
// Brief   : 20-bit relay bit history with start/end pattern comparators.
// Revision: 1.0 - initial release
// ============================================================================
module relay_frame_detect
    import relay_defs::*;
#(
    parameter logic [7:0]  START_READER   = START_READER_DEF,
    parameter logic [7:0]  START_TAG      = START_TAG_DEF,
    parameter logic [15:0] END_ALT_READER = END_ALT_READER_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic shift_i,
    input  logic clear_i,
    input  logic rx_bit_i,
    output logic start_hit_reader_o,
    output logic start_hit_tag_o,
    output logic end_hit_zero_o,
    output logic end_hit_alt_o
);

    logic [19:0] sr_q;
    logic [19:0] w_sr_shift;

    // Comparators look at the value sr will hold once the current bit is in,
    // so a pattern is recognised on the very tick its last bit arrives.
    assign w_sr_shift = {sr_q[18:0], rx_bit_i};

    assign start_hit_reader_o = (w_sr_shift == {12'b0, START_READER});
    assign start_hit_tag_o    = (w_sr_shift == {12'b0, START_TAG});
    assign end_hit_zero_o     = (w_sr_shift[15:0] == 16'h0000);
    assign end_hit_alt_o      = (w_sr_shift[15:0] == END_ALT_READER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else if (clear_i) begin
            sr_q <= '0;
        end else if (shift_i) begin
            sr_q <= w_sr_shift;
        end
    end

endmodule
`default_nettype wire

// File: rtl/relay_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : relay_link_ctrl
// Brief   : Half-duplex relay link sequencer: hunt, frame, guard, timeout.
// Revision: 1.0 - initial release
// ============================================================================
module relay_link_ctrl
    import relay_defs::*;
#(
    parameter logic [7:0]  START_READER   = START_READER_DEF,
    parameter logic [7:0]  START_TAG      = START_TAG_DEF,
    parameter logic [15:0] END_ALT_READER = END_ALT_READER_DEF,
    parameter int          MAX_FRAME_BITS = 4096,
    parameter int          GUARD_BITS     = 16,
    parameter int          CNT_W          = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       hi_simulate_mod_type,
    input  logic             bit_tick,
    input  logic             rx_bit,
    output logic [2:0]       mod_type,
    output logic             relay_tx_en,
    output logic             frame_active,
    output logic [CNT_W-1:0] frame_bits,
    output logic [7:0]       frame_count,
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0] MIN_END_BITS = CNT_W'(16);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MAX_FRAME_BITS - 1);
    localparam int               GUARD_LAST_I = (GUARD_BITS > 0) ? GUARD_BITS - 1 : 0;
    localparam logic [15:0]      GUARD_LAST   = 16'(GUARD_LAST_I);

    state_t           state_q, state_d;
    role_t            role_q, role_d;
    logic [2:0]       mod_type_q, mod_type_d;
    logic             tx_en_q, tx_en_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] fbits_q, fbits_d;
    logic [7:0]       fcount_q, fcount_d;
    logic             tout_q, tout_d;
    logic [15:0]      guard_q, guard_d;

    role_t            w_role_now;
    logic             w_sr_shift;
    logic             w_sr_clear;
    logic             w_start_rd, w_start_tag, w_end_zero, w_end_alt;
    logic             w_start_hit;
    logic             w_end_hit;
    logic [CNT_W-1:0] w_cnt_inc;

    relay_frame_detect #(
        .START_READER  (START_READER),
        .START_TAG     (START_TAG),
        .END_ALT_READER(END_ALT_READER)
    ) u_detect (
        .clk               (clk),
        .reset             (reset),
        .shift_i           (w_sr_shift),
        .clear_i           (w_sr_clear),
        .rx_bit_i          (rx_bit),
        .start_hit_reader_o(w_start_rd),
        .start_hit_tag_o   (w_start_tag),
        .end_hit_zero_o    (w_end_zero),
        .end_hit_alt_o     (w_end_alt)
    );

    assign w_role_now  = decode_role(hi_simulate_mod_type);
    assign w_cnt_inc   = (&fbits_q) ? fbits_q : fbits_q + 1'b1;
    assign w_start_hit = (role_q == ROLE_READER) ? w_start_rd : w_start_tag;
    // End is judged on the post-tick count so it lands on byte boundaries.
    assign w_end_hit   = (w_cnt_inc[2:0] == 3'b000) && (w_cnt_inc >= MIN_END_BITS) &&
                         (w_end_zero || ((role_q == ROLE_READER) && w_end_alt));

    always_comb begin
        state_d    = state_q;
        role_d     = role_q;
        mod_type_d = mod_type_q;
        tx_en_d    = tx_en_q;
        active_d   = active_q;
        fbits_d    = fbits_q;
        fcount_d   = fcount_q;
        tout_d     = tout_q;
        guard_d    = guard_q;
        w_sr_shift = 1'b0;
        w_sr_clear = 1'b0;

        if (state_q != ST_IDLE && w_role_now != role_q) begin
            state_d    = ST_IDLE;
            role_d     = ROLE_NONE;
            mod_type_d = MODE_SNIFFER;
            tx_en_d    = 1'b0;
            active_d   = 1'b0;
            fbits_d    = '0;
            tout_d     = 1'b0;
            guard_d    = '0;
            w_sr_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_role_now != ROLE_NONE) begin
                        state_d    = ST_HUNT;
                        role_d     = w_role_now;
                        mod_type_d = listen_code(w_role_now);
                        tx_en_d    = 1'b1;
                        w_sr_clear = 1'b1;
                    end
                end
                ST_HUNT: begin
                    if (bit_tick) begin
                        w_sr_shift = 1'b1;
                        if (w_start_hit) begin
                            state_d    = ST_ACTIVE;
                            mod_type_d = mod_code(role_q);
                            tx_en_d    = 1'b0;
                            active_d   = 1'b1;
                            fbits_d    = '0;
                            tout_d     = 1'b0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (bit_tick) begin
                        w_sr_shift = 1'b1;
                        fbits_d    = w_cnt_inc;
                        if (w_end_hit || fbits_q == TIMEOUT_LAST) begin
                            state_d    = ST_GUARD;
                            mod_type_d = listen_code(role_q);
                            tx_en_d    = 1'b1;
                            active_d   = 1'b0;
                            fcount_d   = fcount_q + 8'd1;
                            tout_d     = !w_end_hit;
                            guard_d    = '0;
                            w_sr_clear = 1'b1;
                        end
                    end
                end
                ST_GUARD: begin
                    if (bit_tick) begin
                        if (guard_q >= GUARD_LAST) begin
                            state_d = ST_HUNT;
                            guard_d = '0;
                        end else begin
                            guard_d = guard_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            role_q     <= ROLE_NONE;
            mod_type_q <= MODE_SNIFFER;
            tx_en_q    <= 1'b0;
            active_q   <= 1'b0;
            fbits_q    <= '0;
            fcount_q   <= '0;
            tout_q     <= 1'b0;
            guard_q    <= '0;
        end else begin
            state_q    <= state_d;
            role_q     <= role_d;
            mod_type_q <= mod_type_d;
            tx_en_q    <= tx_en_d;
            active_q   <= active_d;
            fbits_q    <= fbits_d;
            fcount_q   <= fcount_d;
            tout_q     <= tout_d;
            guard_q    <= guard_d;
        end
    end

    assign mod_type     = mod_type_q;
    assign relay_tx_en  = tx_en_q;
    assign frame_active = active_q;
    assign frame_bits   = fbits_q;
    assign frame_count  = fcount_q;
    assign timeout_err  = tout_q;

endmodule
`default_nettype wire

// File: doc/relay_link_ctrl.md
Name: relay_link_ctrl

Overview:
Sequences the half-duplex relay link for FAKE_READER and FAKE_TAG operation.
- Watches the decoded relay bitstream at the 0.8475 MHz bit strobe.
- Detects frame start/end patterns and drives mod_type (LISTEN/MOD) for the front end.
- Gates the relay encoder, enforces a post-frame guard time and a maximum-frame timeout.
- Sits between relay_decode/relay_encode and the hi_simulate mode logic; replaces ad-hoc mode switching.

Parameters:
START_READER, 8'h0c, reader-frame start pattern (low byte of 20-bit window, upper 12 bits zero)
START_TAG, 8'hf0, tag-frame start pattern (same framing)
END_ALT_READER, 16'hc000, alternate reader end pattern (reader role only)
MAX_FRAME_BITS, 4096, bit ticks in ACTIVE before forced timeout
GUARD_BITS, 16, bit ticks of forced listen after a frame ends
CNT_W, 13, width of frame_bits counter (must hold MAX_FRAME_BITS)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
hi_simulate_mod_type  in  3  requested role; FAKE_READER=5, FAKE_TAG=6, others = idle
bit_tick  in  1  one-clk strobe per bit period (clk/16)
rx_bit  in  1  decoded relay bit, valid when bit_tick=1
mod_type  out  3  front-end mode code (SNIFFER/TAGSIM_LISTEN/TAGSIM_MOD/READER_LISTEN/READER_MOD)
relay_tx_en  out  1  1 = relay encoder may forward the local signal
frame_active  out  1  1 while in ACTIVE
frame_bits  out  CNT_W  bit ticks elapsed in current frame
frame_count  out  8  completed frames (end or timeout), wraps 255->0
timeout_err  out  1  sticky: last frame ended by timeout

Behaviour:
- Reset (reset=0, async): state IDLE, mod_type=3'b000, relay_tx_en=0, frame_active=0, frame_bits=0, frame_count=0, timeout_err=0, shift register 0.
- All outputs registered. State and outputs update on the clk edge where bit_tick=1; the result is visible on the next cycle. Exception: role change acts on any clk.
- Role: reader if hi_simulate_mod_type==5, tag if 6, else none. LISTEN code: 3 reader / 1 tag. MOD code: 4 reader / 2 tag.
- Shift register sr[19:0] <= {sr[18:0], rx_bit} on every bit_tick in HUNT and ACTIVE.
- IDLE: mod_type=0, relay_tx_en=0. Role valid -> HUNT on the next clk with sr cleared.
- HUNT: mod_type=LISTEN, relay_tx_en=1.
  - Match condition: sr (after shift) == {12'b0, START_role}.
  - On match: go to ACTIVE; mod_type=MOD, relay_tx_en=0, frame_active=1, frame_bits=0, timeout_err=0.
- ACTIVE: frame_bits increments per tick; saturates at all-ones.
  - End condition: frame_bits[2:0]==0 AND frame_bits>=16 AND (sr[15:0]==0 OR (reader AND sr[15:0]==END_ALT_READER)).
  - On end: go to GUARD; frame_count+1.
  - Else if frame_bits==MAX_FRAME_BITS-1: go to GUARD; timeout_err=1, frame_count+1.
  - End and timeout on the same tick: end wins, timeout_err stays 0.
- GUARD: mod_type=LISTEN, relay_tx_en=1, frame_active=0.
  - Start detection disabled; sr held at 0.
  - After GUARD_BITS ticks, go to HUNT. GUARD_BITS=0 means HUNT on the next tick.
- Role change while in a role (differs from the latched role, including to none):
  - Next clk: IDLE; frame_active=0, timeout_err=0, frame_bits=0, sr=0.
  - frame_count is kept; the aborted frame is not counted.
  - The new role then enters HUNT one clk later.
- bit_tick held high continuously is legal: one bit per clk.
- frame_count wraps silently.

Decomposition:
- Package relay_defs: mode codes (SNIFFER..FAKE_TAG), START/END pattern constants, FSM state encoding (IDLE, HUNT, ACTIVE, GUARD).
- Sub-module relay_frame_detect: owns sr[19:0] with shift/clear controls. Emits start_hit_reader, start_hit_tag, end_hit_zero, end_hit_alt combinationally from sr.
- relay_link_ctrl holds the FSM, counters and output registers.

Test Plan:
- Reset: assert reset=0 mid-ACTIVE -> all outputs zero immediately (async); after release with role=5, mod_type=3 two clks later.
- Reader start: role=5, feed bits 0x0000c MSB-first -> tick after the last bit: mod_type=4, frame_active=1, relay_tx_en=0.
- Reader end: in ACTIVE, after 24 bits feed 16 zeros byte-aligned -> mod_type=3, frame_count=1, timeout_err=0; start pattern during the next 16 ticks ignored; accepted afterwards.
- Alternate end: role=5, bytes 0xc0,0x00 byte-aligned -> GUARD. Same pattern with role=6 -> stays ACTIVE.
- Timeout: role=6, start 0xf0, then alternating 1/0 for 4096 ticks -> mod_type=1, timeout_err=1, frame_count=1; next valid start clears timeout_err.
- Role switch: in ACTIVE (role=6) change to 5 -> one IDLE clk with mod_type=0, then mod_type=3; frame_count unchanged; role=0 -> mod_type=0 held.
